// File: rtl/mod_counter_ud.sv
// mod_counter_ud: prescaled modulo-LIMIT up/down counter with wrap or saturate ends.
// Define MODCNT_LOAD_EN to add the iLoad/iLoadVal synchronous load port.
module mod_counter_ud #(
   parameter int  LIMIT    = 60,
   parameter int  PRESCALE = 1,
   parameter int  WRAP     = 1,
   localparam int W        = ($clog2(LIMIT) > 1) ? $clog2(LIMIT) : 1,
   localparam int PW       = ($clog2(PRESCALE) > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iEn,
   input  logic         iDir,
   input  logic         iClr,
`ifdef MODCNT_LOAD_EN
   input  logic         iLoad,
   input  logic [W-1:0] iLoadVal,
`endif
   output logic [W-1:0] oValue,
   output logic         oStrb,
   output logic         oTc
);
   localparam logic [W-1:0]  TOP     = W'(LIMIT - 1);
   localparam logic [W-1:0]  NEAR    = W'(LIMIT - 2);
   localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);
   logic [W-1:0]  value;
   logic [W-1:0]  valNext;
   logic [PW-1:0] pre;
   logic          step;
   logic          atTop;
   logic          atBot;
   logic          strbNext;
   assign oValue = value;
   always_comb begin
      step     = iEn && (pre == PRE_TOP);
      atTop    = value == TOP;
      atBot    = value == '0;
      oTc      = step && (iDir ? atBot : atTop);
      valNext  = iDir ? (atBot ? ((WRAP != 0) ? TOP : '0) : value - W'(1))
                      : (atTop ? ((WRAP != 0) ? '0 : TOP) : value + W'(1));
      // Saturating mode pulses on arrival at the end, not while parked there.
      strbNext = (WRAP != 0) ? oTc : step && (iDir ? value == W'(1) : value == NEAR);
   end
`ifdef MODCNT_LOAD_EN
   logic [W-1:0] loadVal;
   assign loadVal = ({1'b0, iLoadVal} >= (W + 1)'(LIMIT)) ? TOP : iLoadVal;
`endif
   always_ff @(posedge iClk) begin
      if (!iRst || iClr) begin
         value <= '0;
         pre   <= '0;
         oStrb <= 1'b0;
      end
`ifdef MODCNT_LOAD_EN
      else if (iLoad) begin
         value <= loadVal;
         pre   <= '0;
         oStrb <= 1'b0;
      end
`endif
      else begin
         if (iEn) pre <= (pre == PRE_TOP) ? '0 : pre + PW'(1);
         if (step) value <= valNext;
         oStrb <= strbNext;
      end
   end
endmodule
